// File: rtl/riscv_mmio_pkg.sv
// riscv_mmio_pkg: shared MMIO window, register map, STATUS layout and UART FSM states.
package riscv_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h0010_0000;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A divisor of 0 behaves like 1; the bit timer counts down from N-1.
    function automatic logic [15:0] bit_period_m1(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 console transmitter with TX FIFO, STATUS and BAUDDIV registers.
module mmio_uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = MMIO_BASE,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [29:0] MADDR,
    input  logic [31:0] MDATAO,
    input  logic [3:0]  MWSTB,
    input  logic        MWE,
    input  logic        MRE,
    output logic [31:0] MDATAI,
    output logic        HIT,
    output logic        TXD,
    output logic        BUSY
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        hit, wr, push, pop, ovf_clr;
    logic [1:0]  idx;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] fifo_cnt;
    logic [31:0] status, rd_mux;
    logic [15:0] n_m1, div_d;
    logic        unused_ok;

    logic        ovf_q, hit_q, txd_q;
    logic [31:0] rdata_q;
    logic [15:0] div_q, cnt_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    tx_state_e   state_q;

    assign hit     = (MADDR[29:2] == BASE_ADDR[31:4]);
    assign idx     = MADDR[1:0];
    assign wr      = MWE && hit;
    assign push    = wr && (idx == REG_TXDATA) && MWSTB[0];
    assign ovf_clr = wr && (idx == REG_STATUS) && MWSTB[0] && MDATAO[ST_OVF];
    assign n_m1    = bit_period_m1(div_q);
    assign pop     = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_q == 16'd0));
    assign unused_ok = ^{MDATAO[31:16], MWSTB[3:2]};

    assign div_d = (wr && idx == REG_BAUDDIV) ?
                   {MWSTB[1] ? MDATAO[15:8] : div_q[15:8], MWSTB[0] ? MDATAO[7:0] : div_q[7:0]} : div_q;

    always_comb begin
        status = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = (state_q != S_IDLE);
        status[ST_OVF]   = ovf_q;
        status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_cnt);
    end

    assign rd_mux = (idx == REG_STATUS)  ? status :
                    (idx == REG_BAUDDIV) ? {16'd0, div_q} : 32'd0;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (MDATAO[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q   <= 1'b0;
            div_q   <= DEFAULT_DIV;
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ovf_q   <= (push && fifo_full) || (ovf_q && !ovf_clr);
            div_q   <= div_d;
            hit_q   <= hit && (MRE || MWE);
            rdata_q <= (MRE && hit) ? rd_mux : 32'd0;
        end
    end

    // TXD is re-registered from the state, so the line lags the FSM by one clock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            txd_q <= (state_q == S_START) ? 1'b0 : (state_q == S_DATA) ? shift_q[0] : 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        cnt_q   <= n_m1;
                        bit_q   <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= n_m1;
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= n_m1;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    if (cnt_q == 16'd0) begin
                        if (!fifo_empty) begin
                            shift_q <= fifo_dout;
                            cnt_q   <= n_m1;
                            bit_q   <= '0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign MDATAI = rdata_q;
    assign HIT    = hit_q;
    assign TXD    = txd_q;
    assign BUSY   = (state_q != S_IDLE);

endmodule
